// File: rtl/conv_ctrl_regs_if.sv
// AXI4-Lite slave bus bundle for the convolution control registers.
interface conv_ctrl_regs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/conv_ctrl_regs.sv
// Register file and frame sequencer for the convolution datapath: kernel
// coefficients, frame length, control/status, and one-frame run-enable per START.
module conv_ctrl_regs #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int COEFF_WIDTH = 8
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset_n,
    conv_ctrl_regs_if.slave          s_axi,
    input  logic                     beat_accepted,
    output logic                     conv_enable,
    output logic [9*COEFF_WIDTH-1:0] coeff_flat,
    output logic                     irq
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;

    logic                          irq_en;
    logic                          done;
    logic [DATA_WIDTH-1:0]         frame_len;
    logic [DATA_WIDTH-1:0]         beat_count;
    logic signed [COEFF_WIDTH-1:0] coeff [9];

    logic                  busy;
    logic                  wr_start, wr_hs, rd_start, rd_hs;
    logic [3:0]            wr_idx, rd_idx;
    logic                  wr_cfg, wr_err, wr_cfg_en;
    logic                  start_cmd, soft_clr, done_w1c;
    logic                  done_set, cnt_clr, cnt_inc;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [1:0]            rd_resp;
    logic                  unused_addr;

    function automatic logic [DATA_WIDTH-1:0] sign_extend(input logic signed [COEFF_WIDTH-1:0] c);
        return {{(DATA_WIDTH-COEFF_WIDTH){c[COEFF_WIDTH-1]}}, c};
    endfunction

    assign busy        = (state == RUN);
    assign conv_enable = busy;
    assign unused_addr = ^{s_axi.awaddr[ADDR_WIDTH-1:6], s_axi.awaddr[1:0],
                           s_axi.araddr[ADDR_WIDTH-1:6], s_axi.araddr[1:0]};

    // Write decode: configuration registers are frozen while a frame runs
    assign wr_idx    = s_axi.awaddr[5:2];
    assign wr_start  = s_axi.awvalid & s_axi.wvalid & ~s_axi.bvalid & ~s_axi.awready;
    assign wr_hs     = s_axi.awvalid & s_axi.awready & s_axi.wvalid & s_axi.wready;
    assign wr_cfg    = (wr_idx == 4'd2) || ((wr_idx >= 4'd4) && (wr_idx <= 4'd12));
    assign wr_err    = (wr_idx > 4'd12) || (wr_cfg && busy);
    assign wr_cfg_en = wr_hs & wr_cfg & ~busy;
    assign start_cmd = wr_hs & (wr_idx == 4'd0) & s_axi.wdata[0];
    assign soft_clr  = wr_hs & (wr_idx == 4'd0) & s_axi.wdata[2];
    assign done_w1c  = wr_hs & (wr_idx == 4'd1) & s_axi.wdata[1];

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) state <= IDLE;
        else              state <= state_next;
    end

    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        if (soft_clr) begin
            state_next = IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cmd) begin
                        if (frame_len != '0) begin
                            state_next = RUN;
                            cnt_clr    = 1'b1;
                        end else begin
                            done_set = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (beat_accepted) begin
                        cnt_inc = 1'b1;
                        if ((beat_count + DATA_WIDTH'(1)) == frame_len) begin
                            done_set   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A sequencer set of DONE outranks a simultaneous W1C
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            beat_count <= '0;
            done       <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (cnt_clr)      beat_count <= '0;
            else if (cnt_inc) beat_count <= beat_count + DATA_WIDTH'(1);
            if (soft_clr)      done <= 1'b0;
            else if (done_set) done <= 1'b1;
            else if (done_w1c) done <= 1'b0;
            irq <= done & irq_en;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            irq_en    <= 1'b0;
            frame_len <= '0;
            for (int i = 0; i < 9; i++) coeff[i] <= '0;
        end else begin
            if (wr_hs && (wr_idx == 4'd0)) irq_en <= s_axi.wdata[1];
            if (wr_cfg_en) begin
                if (wr_idx == 4'd2) frame_len <= s_axi.wdata;
                else                coeff[wr_idx - 4'd4] <= s_axi.wdata[COEFF_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        coeff_flat = '0;
        for (int i = 0; i < 9; i++) coeff_flat[i*COEFF_WIDTH +: COEFF_WIDTH] = coeff[i];
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= RESP_OKAY;
        end else begin
            s_axi.awready <= wr_start;
            s_axi.wready  <= wr_start;
            if (s_axi.bvalid && s_axi.bready) s_axi.bvalid <= 1'b0;
            if (wr_hs) begin
                s_axi.bvalid <= 1'b1;
                s_axi.bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Read path: decode sampled at the address handshake, held until rready
    assign rd_idx   = s_axi.araddr[5:2];
    assign rd_start = s_axi.arvalid & ~s_axi.rvalid & ~s_axi.arready;
    assign rd_hs    = s_axi.arvalid & s_axi.arready;

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (rd_idx)
            4'd0: rd_word[1]   = irq_en;
            4'd1: rd_word[1:0] = {done, busy};
            4'd2: rd_word      = frame_len;
            4'd3: rd_word      = beat_count;
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
                  rd_word      = sign_extend(coeff[rd_idx - 4'd4]);
            default: rd_resp   = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RESP_OKAY;
        end else begin
            s_axi.arready <= rd_start;
            if (s_axi.rvalid && s_axi.rready) s_axi.rvalid <= 1'b0;
            if (rd_hs) begin
                s_axi.rvalid <= 1'b1;
                s_axi.rdata  <= rd_word;
                s_axi.rresp  <= rd_resp;
            end
        end
    end
endmodule

// File: doc/conv_ctrl_regs.md
# conv_ctrl_regs

AXI4-Lite configuration and frame-sequencing controller for the convolution datapath. Holds the 3x3 kernel coefficients, frame length and control/status registers, and drives the datapath's run-enable for exactly one frame of stream beats per START command. It raises a level interrupt on frame completion and sits between the PS AXI4-Lite master and the AXI4-Stream convolution block.

## Interface
- DATA_WIDTH, 32: AXI4-Lite data width; register width.
- ADDR_WIDTH, 10: AXI4-Lite byte address width; bits [5:2] decode the register, upper bits ignored.
- COEFF_WIDTH, 8: signed kernel coefficient width.

- axi_clk  in  1  single clock for all logic.
- axi_reset_n  in  1  asynchronous, active-low reset.
- s_axi_awaddr / s_axi_awvalid / s_axi_awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- s_axi_wdata / s_axi_wvalid / s_axi_wready  in/in/out  DATA_WIDTH/1/1  write data channel; no strobes, full-word writes.
- s_axi_bresp / s_axi_bvalid / s_axi_bready  out/out/in  2/1/1  write response.
- s_axi_araddr / s_axi_arvalid / s_axi_arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
- s_axi_rdata / s_axi_rresp / s_axi_rvalid / s_axi_rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- beat_accepted  in  1  one-cycle pulse per stream beat accepted by the datapath (s_axis valid&ready).
- conv_enable  out  1  datapath run-enable; high only in RUN.
- coeff_flat  out  9*COEFF_WIDTH  coefficients, COEFF0 in bits [COEFF_WIDTH-1:0].
- irq  out  1  registered DONE & IRQ_EN.

## Operation
- Register map (byte offset): 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN, bit2 SOFT_CLR (write-1 pulse, reads 0). 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (write-1-to-clear). 0x08 FRAME_LEN (RW, beats per frame). 0x0C BEAT_COUNT (RO). 0x10..0x30 COEFF0..COEFF8 (RW, low COEFF_WIDTH bits; read sign-extended).
- Unmapped offsets: reads return 0 with RRESP=2'b10 (SLVERR); writes are dropped with BRESP=2'b10.
- A COEFFn or FRAME_LEN write while BUSY is dropped with BRESP=SLVERR, keeping the configuration stable during a frame. All other responses are OKAY (2'b00).
- Sequencer FSM, states IDLE and RUN:
  - IDLE -> RUN on START with FRAME_LEN != 0. BEAT_COUNT clears to 0 on entry.
  - START with FRAME_LEN == 0 sets DONE immediately and stays in IDLE.
  - RUN: each beat_accepted increments BEAT_COUNT. The beat that makes BEAT_COUNT == FRAME_LEN sets DONE and returns to IDLE.
  - START while in RUN is ignored (BRESP still OKAY).
  - SOFT_CLR in any state: go to IDLE, BEAT_COUNT=0, DONE=0. IRQ_EN, FRAME_LEN and coefficients are preserved.
- DONE set by the sequencer and W1C in the same cycle: set wins.
- BEAT_COUNT is DATA_WIDTH wide; beat_accepted in IDLE is ignored.

## Timing
- Reset values: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; conv_enable = 0; irq = 0; coeff_flat = 0; all registers 0; FSM in IDLE. Reset mid-frame aborts immediately and asynchronously.
- Write handshake: awready and wready rise together for exactly one cycle, in the cycle after both awvalid and wvalid are high and bvalid is low. The register updates on that handshake edge. bvalid rises the next cycle and holds until bready.
- Read handshake: arready pulses one cycle after arvalid when rvalid is low. rdata/rresp/rvalid are registered the next cycle and held stable until rready.
- Only one outstanding write and one outstanding read. Reads and writes proceed independently.
- START takes effect the cycle after the write handshake: conv_enable is high from handshake+1.
- The final beat_accepted pulse drops conv_enable and sets DONE on the same edge. irq follows DONE one cycle later.
- coeff_flat updates one cycle after the write handshake.

## Test plan
- Reset: assert axi_reset_n=0 mid-RUN -> conv_enable, irq, all handshake outputs 0 immediately. All registers read 0 after release.
- Coefficients: write COEFF0..8 = 1..9, with COEFF4 = 0xFF -> coeff_flat matches. COEFF4 reads 0xFFFFFFFF. All BRESP OKAY.
- Frame run: FRAME_LEN=4, IRQ_EN=1, START, then 4 beat_accepted pulses with gaps -> BEAT_COUNT 1..4. conv_enable falls on the 4th beat. DONE=1, irq=1 one cycle later. W1C to DONE drops irq.
- Busy protection: during RUN, write COEFF2 and FRAME_LEN -> BRESP=2'b10, values unchanged. START during RUN is ignored.
- Edge cases: FRAME_LEN=0 + START -> DONE=1 with no RUN. Read 0x3C -> rdata 0, RRESP=2'b10. W1C to DONE on the same cycle DONE is set -> DONE remains 1.
- Backpressure and abort: hold bready/rready low for 5 cycles -> bvalid/rvalid and data stable, no new awready/arready. SOFT_CLR mid-frame -> IDLE, BEAT_COUNT=0, FRAME_LEN retained.
